// File: rtl/hack_data_memory.sv
// ---------------------------------------------------------------------------
// hack_data_memory
//
// Data-side memory responder for the Hack CPU. It decodes the 15-bit word
// address into a 16K-word RAM, an 8K-word screen buffer and the keyboard
// register. Screen writes can also be streamed to a display engine through a
// small FIFO with a valid/ready handshake.
//
// Optional feature macro: HACK_SCREEN_FIFO_EN
//   defined   - the screen-update FIFO and display handshake are built.
//   undefined - no FIFO; dispValid/dispAddress/dispData/overflow tied 0,
//               dispReady ignored. Screen words are still stored and readable.
//
// Parameters:
//   FIFO_DEPTH   screen-update FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   memAddress   CPU word address (A[14:0])
//   memOut       CPU write data
//   writeM       CPU write strobe
//   memIn        read data, combinational from memAddress
//   keyValid     keyboard scan-code strobe
//   keyCode      keyboard scan code (0 = no key)
//   dispValid    FIFO head entry is valid
//   dispAddress  screen word offset of the head entry
//   dispData     pixel word of the head entry
//   dispReady    display engine accepts the head entry
//   overflow     sticky: a screen update was dropped on a full FIFO
//   badAccess    sticky: a write hit the keyboard or an unmapped address
// ---------------------------------------------------------------------------
module hack_data_memory #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] memAddress,
    input  logic [15:0] memOut,
    input  logic        writeM,
    output logic [15:0] memIn,
    input  logic        keyValid,
    input  logic [15:0] keyCode,
    output logic        dispValid,
    output logic [12:0] dispAddress,
    output logic [15:0] dispData,
    input  logic        dispReady,
    output logic        overflow,
    output logic        badAccess
);

    // ---------------- address decode ----------------
    logic is_ram;
    logic is_scr;
    logic is_kbd;
    logic write_en;

    assign is_ram   = (memAddress[14] == 1'b0);
    assign is_scr   = (memAddress[14:13] == 2'b10);
    assign is_kbd   = (memAddress == 15'h6000);
    // Writes are suppressed while reset is held.
    assign write_en = writeM && !reset;

    // ---------------- storage ----------------
    // Reads are combinational, so these map to distributed RAM.
    logic [15:0] ram_mem [16384];
    logic [15:0] scr_mem [8192];

    always_ff @(posedge clk) begin
        if (write_en && is_ram) begin
            ram_mem[memAddress[13:0]] <= memOut;
        end
        if (write_en && is_scr) begin
            scr_mem[memAddress[12:0]] <= memOut;
        end
    end

    // ---------------- keyboard and error flag ----------------
    logic [15:0] kbd_q, kbd_d;
    logic        bad_q, bad_d;

    always_comb begin
        kbd_d = kbd_q;
        bad_d = bad_q;
        if (keyValid) begin
            kbd_d = keyCode;
        end
        if (write_en && !is_ram && !is_scr) begin
            bad_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_q <= 16'h0000;
            bad_q <= 1'b0;
        end else begin
            kbd_q <= kbd_d;
            bad_q <= bad_d;
        end
    end

    assign badAccess = bad_q;

    // ---------------- read mux ----------------
    always_comb begin
        memIn = 16'h0000;
        if (is_ram) begin
            memIn = ram_mem[memAddress[13:0]];
        end else if (is_scr) begin
            memIn = scr_mem[memAddress[12:0]];
        end else if (is_kbd) begin
            memIn = kbd_q;
        end
    end

`ifdef HACK_SCREEN_FIFO_EN
    // ---------------- screen-update FIFO ----------------
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [12:0]      fifo_addr_mem [FIFO_DEPTH];
    logic [15:0]      fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, full, push_ok;

    always_comb begin
        full       = (count_q == DEPTH_C);
        pop        = (count_q != '0) && dispReady;
        push       = write_en && is_scr;
        // A pop on the same edge frees the slot the push needs.
        push_ok    = push && (!full || pop);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // push_ok already excludes reset through write_en.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr_mem[wr_ptr_q] <= memAddress[12:0];
            fifo_data_mem[wr_ptr_q] <= memOut;
        end
    end

    assign dispValid   = (count_q != '0);
    assign dispAddress = fifo_addr_mem[rd_ptr_q];
    assign dispData    = fifo_data_mem[rd_ptr_q];
    assign overflow    = overflow_q;
`else
    // Display path not built: outputs idle, handshake input unused.
    logic fifo_unused;
    assign fifo_unused = ^{dispReady, 32'(FIFO_DEPTH)};

    assign dispValid   = 1'b0;
    assign dispAddress = 13'h0000;
    assign dispData    = 16'h0000;
    assign overflow    = 1'b0;
`endif

endmodule
